// File: rtl/array_rw_masked.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | array_rw_masked: banked single-port array, lane write masks, zero-init.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module array_rw_masked #(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 12,
  parameter int MASK_GRAN = 8,
  parameter int NUM_BANKS = 4,
  parameter int OUT_REG   = 0
) (
  input  logic                          RW0_clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             RW0_addr,
  input  logic                          RW0_en,
  input  logic                          RW0_wmode,
  input  logic [DATA_W-1:0]             RW0_wdata,
  input  logic [DATA_W/MASK_GRAN-1:0]   RW0_wmask,
  output logic                          RW0_ready,
  output logic [DATA_W-1:0]             RW0_rdata,
  output logic                          RW0_rvalid
);

  localparam int MASK_W     = DATA_W / MASK_GRAN;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int BANK_W     = $clog2(NUM_BANKS);
  localparam int BSEL_W     = (BANK_W > 0) ? BANK_W : 1;
  localparam int BANK_DEPTH = DEPTH / NUM_BANKS;
  localparam int ROW_W      = (ADDR_W - BANK_W > 0) ? (ADDR_W - BANK_W) : 1;
  localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(BANK_DEPTH - 1);

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   idx_q, idx_d;
  logic               rvalid1_q, rvalid1_d;
  logic [BSEL_W-1:0]  sel_q, sel_d;

  logic [BSEL_W-1:0]  bank;
  logic [ROW_W-1:0]   row;
  logic               acc;
  logic               rd_acc;
  logic               wr_acc;
  logic               init_we;
  logic [DATA_W-1:0]  bank_rdata [NUM_BANKS];
  logic [DATA_W-1:0]  mux_rdata;

  // Low address bits pick the bank so consecutive words land in different banks.
  assign bank      = (NUM_BANKS > 1) ? BSEL_W'(RW0_addr) : '0;
  assign row       = ROW_W'(RW0_addr >> BANK_W);
  assign RW0_ready = (state_q == READY);
  assign acc       = RW0_en && RW0_ready;
  assign rd_acc    = acc && !RW0_wmode;
  assign wr_acc    = acc && RW0_wmode;
  assign init_we   = (state_q == INIT) && !reset;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    rvalid1_d = rd_acc;
    if (rd_acc) begin
      sel_d = bank;
    end
    if (state_q == INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d = READY;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      state_q   <= INIT;
      idx_q     <= '0;
      rvalid1_q <= 1'b0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rvalid1_q <= rvalid1_d;
      sel_q     <= sel_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [BANK_DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              hit;

    assign hit = (bank == BSEL_W'(b));

    always_ff @(posedge RW0_clk) begin
      if (init_we) begin
        mem[idx_q] <= '0;
      end else if (wr_acc && hit) begin
        for (int l = 0; l < MASK_W; l++) begin
          if (RW0_wmask[l]) begin
            mem[row][l*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[l*MASK_GRAN +: MASK_GRAN];
          end
        end
      end
    end

    // Only loaded on a read of this bank, so the output holds between reads.
    always_ff @(posedge RW0_clk) begin
      if (reset) begin
        rd_q <= '0;
      end else if (rd_acc && hit) begin
        rd_q <= mem[row];
      end
    end

    assign bank_rdata[b] = rd_q;
  end

  assign mux_rdata = bank_rdata[sel_q];

  if (OUT_REG != 0) begin : g_out_reg
    logic              rvalid2_q, rvalid2_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;

    always_comb begin
      rvalid2_d = rvalid1_q;
      rdata2_d  = rvalid1_q ? mux_rdata : rdata2_q;
    end

    always_ff @(posedge RW0_clk) begin
      if (reset) begin
        rvalid2_q <= 1'b0;
        rdata2_q  <= '0;
      end else begin
        rvalid2_q <= rvalid2_d;
        rdata2_q  <= rdata2_d;
      end
    end

    assign RW0_rvalid = rvalid2_q;
    assign RW0_rdata  = rdata2_q;
  end else begin : g_no_out_reg
    assign RW0_rvalid = rvalid1_q;
    assign RW0_rdata  = mux_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_array_rw_masked.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_array_rw_masked: scoreboard bench for OUT_REG=0 and OUT_REG=1 arrays. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_array_rw_masked;

  localparam int DW = 512;
  localparam int AW = 12;
  localparam int MW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst    [2];
  logic          en     [2];
  logic          wm     [2];
  logic [AW-1:0] addr   [2];
  logic [DW-1:0] wdata  [2];
  logic [MW-1:0] wmask  [2];
  logic          ready  [2];
  logic [DW-1:0] rdata  [2];
  logic          rvalid [2];

  array_rw_masked #(.DATA_W(DW), .ADDR_W(AW), .MASK_GRAN(8), .NUM_BANKS(4), .OUT_REG(0)) dut0 (
    .RW0_clk(clk), .reset(rst[0]), .RW0_addr(addr[0]), .RW0_en(en[0]), .RW0_wmode(wm[0]),
    .RW0_wdata(wdata[0]), .RW0_wmask(wmask[0]), .RW0_ready(ready[0]),
    .RW0_rdata(rdata[0]), .RW0_rvalid(rvalid[0])
  );

  array_rw_masked #(.DATA_W(DW), .ADDR_W(AW), .MASK_GRAN(8), .NUM_BANKS(4), .OUT_REG(1)) dut1 (
    .RW0_clk(clk), .reset(rst[1]), .RW0_addr(addr[1]), .RW0_en(en[1]), .RW0_wmode(wm[1]),
    .RW0_wdata(wdata[1]), .RW0_wmask(wmask[1]), .RW0_ready(ready[1]),
    .RW0_rdata(rdata[1]), .RW0_rvalid(rvalid[1])
  );

  int n_cmp = 0;
  int n_err = 0;
  int rv_cnt [2];
  int exp_rd [2];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] model0 [int];
  logic [DW-1:0] model1 [int];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input int d, input int a);
    if (d == 0) return model0.exists(a) ? model0[a] : '0;
    else        return model1.exists(a) ? model1[a] : '0;
  endfunction

  task automatic model_wr(input int d, input int a, input logic [DW-1:0] data, input logic [MW-1:0] mask);
    logic [DW-1:0] cur;
    cur = model_rd(d, a);
    for (int l = 0; l < MW; l++) begin
      if (mask[l]) cur[l*8 +: 8] = data[l*8 +: 8];
    end
    if (d == 0) model0[a] = cur;
    else        model1[a] = cur;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One request per call; consecutive calls issue back-to-back.
  task automatic req(input int d, input bit w, input int a, input logic [DW-1:0] data, input logic [MW-1:0] mask);
    if (ready[d] !== 1'b1) check("req_ready", {511'b0, ready[d]}, 1);
    en[d] = 1'b1; wm[d] = w; addr[d] = AW'(a); wdata[d] = data; wmask[d] = mask;
    if (w) begin
      model_wr(d, a, data, mask);
    end else begin
      if (d == 0) q0.push_back(model_rd(0, a));
      else        q1.push_back(model_rd(1, a));
      exp_rd[d]++;
    end
    @(posedge clk); #1;
    en[d] = 1'b0;
  endtask

  task automatic pulse_reset(input int d);
    rst[d] = 1'b1;
    if (d == 0) model0.delete();
    else        model1.delete();
    @(posedge clk); #1;
    rst[d] = 1'b0;
  endtask

  task automatic measure_init(input int d, input string tag);
    int n;
    n = 0;
    while (ready[d] !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, DW'(n), DW'(1024));
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (rvalid[0] === 1'b1) begin
      rv_cnt[0]++;
      if (q0.size() == 0) check("unexpected_rvalid0", {511'b0, rvalid[0]}, '0);
      else                check("sb_rdata0", rdata[0], q0.pop_front());
    end
    if (rvalid[1] === 1'b1) begin
      rv_cnt[1]++;
      if (q1.size() == 0) check("unexpected_rvalid1", {511'b0, rvalid[1]}, '0);
      else                check("sb_rdata1", rdata[1], q1.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] e_mask, a_w, b_w, c_w, d_w;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; en[d] = 1'b0; wm[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wmask[d] = '0;
      rv_cnt[d] = 0; exp_rd[d] = 0;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready",  {511'b0, ready[d]}, '0);
      check("rst_rvalid", {511'b0, rvalid[d]}, '0);
      check("rst_rdata",  rdata[d], '0);
      rst[d] = 1'b0;
    end
    measure_init(0, "init_cycles0");
    check("ready1_after_init", {511'b0, ready[1]}, 1);

    // Fresh contents read zero with one-cycle latency.
    req(0, 0, 0, '0, '0);     check("lat_rvalid_a0", {511'b0, rvalid[0]}, 1);
    req(0, 0, 1, '0, '0);     check("lat_rvalid_a1", {511'b0, rvalid[0]}, 1);
    req(0, 0, 4095, '0, '0);  check("lat_rvalid_a4095", {511'b0, rvalid[0]}, 1);
    idle(1);
    check("idle_rvalid", {511'b0, rvalid[0]}, '0);

    // Lane-0 masked overwrite; read right after the write sees it.
    e_mask = '1; e_mask[7:0] = 8'h00;
    req(0, 1, 5, '1, '1);
    req(0, 1, 5, '0, 64'h1);
    req(0, 0, 5, '0, '0);     check("mask_lane0", rdata[0], e_mask);
    req(0, 1, 5, rand_word(), '0);
    req(0, 0, 5, '0, '0);     check("zero_mask_noop", rdata[0], e_mask);

    // Back-to-back reads across banks, then hold.
    a_w = rand_word(); b_w = rand_word();
    req(0, 1, 'h10, a_w, '1);
    req(0, 1, 'h11, b_w, '1);
    req(0, 0, 'h10, '0, '0);
    check("b2b_rvalid_a", {511'b0, rvalid[0]}, 1); check("b2b_rdata_a", rdata[0], a_w);
    req(0, 0, 'h11, '0, '0);
    check("b2b_rvalid_b", {511'b0, rvalid[0]}, 1); check("b2b_rdata_b", rdata[0], b_w);
    idle(1);
    check("hold_rvalid", {511'b0, rvalid[0]}, '0); check("hold_rdata", rdata[0], b_w);
    req(0, 1, 'h12, rand_word(), '1);
    check("hold_after_write", rdata[0], b_w);

    for (int i = 0; i < 40; i++) begin
      req(0, 1'($urandom_range(0, 1)), $urandom_range(0, 31), rand_word(), {$urandom, $urandom});
    end
    idle(2);

    // Requests during INIT are ignored; reset mid-sweep restarts it.
    pulse_reset(0);
    check("init_ready_low", {511'b0, ready[0]}, '0);
    en[0] = 1'b1; wm[0] = 1'b0; addr[0] = '0;
    idle(500);
    en[0] = 1'b0;
    pulse_reset(0);
    measure_init(0, "init_cycles_mid_reset");
    req(0, 0, 5, '0, '0);     check("cleared_a5", rdata[0], '0);
    req(0, 0, 'h11, '0, '0);  check("cleared_a11", rdata[0], '0);
    idle(2);

    // Registered-output variant: two-cycle latency, reset kills in-flight read.
    c_w = rand_word(); d_w = rand_word();
    req(1, 1, 'h20, c_w, '1);
    req(1, 0, 'h20, '0, '0);
    check("or1_t1_rvalid", {511'b0, rvalid[1]}, '0);
    idle(1);
    check("or1_t2_rvalid", {511'b0, rvalid[1]}, 1); check("or1_t2_rdata", rdata[1], c_w);
    req(1, 1, 'h21, d_w, 64'hFF);
    req(1, 0, 'h21, '0, '0);
    req(1, 0, 'h20, '0, '0);
    idle(3);
    en[1] = 1'b1; wm[1] = 1'b0; addr[1] = AW'('h20);
    @(posedge clk); #1;
    en[1] = 1'b0;
    pulse_reset(1);
    check("or1_inflight_rvalid", {511'b0, rvalid[1]}, '0);
    check("or1_reset_rdata", rdata[1], '0);
    check("or1_reset_ready", {511'b0, ready[1]}, '0);
    measure_init(1, "init_cycles_or1");
    req(1, 0, 'h20, '0, '0);
    idle(1);
    check("or1_cleared_rvalid", {511'b0, rvalid[1]}, 1); check("or1_cleared_rdata", rdata[1], '0);
    idle(3);

    check("sb_q0_drained", DW'(q0.size()), '0);
    check("sb_q1_drained", DW'(q1.size()), '0);
    check("rvalid_count0", DW'(rv_cnt[0]), DW'(exp_rd[0]));
    check("rvalid_count1", DW'(rv_cnt[1]), DW'(exp_rd[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/array_rw_masked.md
ARRAY_RW_MASKED -- requirements
Module: array_rw_masked

Interface
REQ-001 SHALL have parameter DATA_W, default 512, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 12, word address width; DEPTH = 2^ADDR_W.
REQ-003 SHALL have parameter MASK_GRAN, default 8, bits per write-mask lane; DATA_W divisible by MASK_GRAN; MASK_W = DATA_W/MASK_GRAN.
REQ-004 SHALL have parameter NUM_BANKS, default 4, power of two, at most DEPTH; bank = addr[log2(NUM_BANKS)-1:0].
REQ-005 SHALL have parameter OUT_REG, default 0, 0 or 1; 1 adds a read output register.
REQ-006 RW0_clk  input  1  sole clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 RW0_addr  input  ADDR_W  word address.
REQ-009 RW0_en  input  1  access request, sampled with RW0_ready.
REQ-010 RW0_wmode  input  1  1 = write, 0 = read.
REQ-011 RW0_wdata  input  DATA_W  write data.
REQ-012 RW0_wmask  input  MASK_W  per-lane write enable, bit i covers bits [i*MASK_GRAN +: MASK_GRAN].
REQ-013 RW0_ready  output  1  array accepts requests this cycle.
REQ-014 RW0_rdata  output  DATA_W  read data.
REQ-015 RW0_rvalid  output  1  one-cycle pulse, RW0_rdata carries a new read result.

Function
REQ-016 Request SHALL be accepted only when RW0_en && RW0_ready in the same cycle; otherwise ignored with no side effect.
REQ-017 Storage SHALL be NUM_BANKS banks of DEPTH/NUM_BANKS words; only the addressed bank SHALL be enabled per accepted request.
REQ-018 Accepted write SHALL update only lanes with mask bit 1; lanes with mask 0 retain prior value; all-zero mask is a no-op write.
REQ-019 Write SHALL NOT change RW0_rdata and SHALL NOT assert RW0_rvalid.
REQ-020 Accepted read SHALL return stored word with latency 1 + OUT_REG cycles; RW0_rvalid pulses high in that cycle.
REQ-021 Read of an address written in the previous cycle SHALL return the post-write value.
REQ-022 RW0_rdata SHALL hold the last read result until the next read result is presented.
REQ-023 Back-to-back accepted requests every cycle SHALL be sustained; throughput one request per cycle in READY.
REQ-024 FSM states: INIT, READY.
REQ-025 INIT: counter idx runs 0 .. DEPTH/NUM_BANKS-1, writing zero to word idx of every bank in parallel, one index per cycle; RW0_ready = 0.
REQ-026 INIT -> READY in the cycle after idx = DEPTH/NUM_BANKS-1 is written; READY persists until reset.
REQ-027 RW0_ready SHALL be 1 exactly in READY.
REQ-028 Read in flight when OUT_REG=1 SHALL complete normally regardless of new requests.

Reset
REQ-029 On reset: state = INIT, idx = 0, RW0_ready = 0, RW0_rvalid = 0, RW0_rdata = 0, output pipeline cleared.
REQ-030 Reset asserted mid-INIT SHALL restart the sweep from idx = 0.
REQ-031 Reset asserted in READY SHALL discard in-flight reads (no rvalid) and rerun the full INIT sweep; all contents read zero afterward.

Verification
REQ-032 Defaults, reset 1 cycle then release -> RW0_ready low exactly 1024 cycles, then high; reads of addr 0, 1, 4095 return 0 with rvalid one cycle after acceptance.
REQ-033 Write addr 0x005 data all-ones mask all-ones, then write addr 0x005 data 0 mask 0x...0001 -> read returns all-ones except bits [7:0] = 0x00.
REQ-034 Write addr 0x010 = A, addr 0x011 = B (different banks), read 0x010, 0x011 back-to-back -> rvalid two consecutive cycles, rdata A then B, rdata holds B afterward.
REQ-035 RW0_en=1 read during INIT, and write with all-zero mask in READY -> no rvalid during INIT, contents unchanged by zero-mask write.
REQ-036 OUT_REG=1: read accepted cycle t -> rvalid and data at t+2; reset asserted at t+1 -> no rvalid, ready low for 1024 cycles, prior data reads 0 afterward.
REQ-037 Reset pulsed at INIT idx = 500 -> ready rises 1024 cycles after reset release, not earlier.
